// File: rtl/pipe_skid_pkg.sv
// Shared types for the skid-buffered pipeline stage.
// The state encoding is also the occupancy level.
package pipe_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } pipe_skid_state_t;

  localparam int LEVEL_W = 2;

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating up-counter for stall cycles.
// Only instantiated when PIPE_SKID_STALL_CNT_EN is defined.
module pipe_stall_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer.
// Optional stall counter: define PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage
  import pipe_skid_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   stall_cnt
);

  pipe_skid_state_t state, state_d;

  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

  logic in_fire, out_fire;
  logic ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = (state != FULL) && !rst;
  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  assign out_data = main_data;
  // Bubbles must never carry live write enables downstream.
  assign out_ctrl = out_valid ? main_ctrl : '0;

  always_comb begin
    level = 2'd0;
    unique case (1'b1)
      (state == BUSY): level = 2'd1;
      (state == FULL): level = 2'd2;
      default:         level = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            ld_main_in = 1'b1;
            state_d    = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            ld_skid = 1'b1;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            ld_main_skid = 1'b1;
            state_d      = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_d;
      if (ld_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (ld_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  pipe_stall_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (out_valid && !out_ready),
    .count(stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage.
// Stall-count expectations follow PIPE_SKID_STALL_CNT_EN.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        level;
  logic [CNT_W-1:0]  stall_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .level    (level),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [CNT_W-1:0] stall_exp [5];

  initial begin
`ifdef PIPE_SKID_STALL_CNT_EN
    stall_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    stall_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_level", level, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_in_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Streaming with the consumer always ready
    in_valid = 1'b1; in_data = 32'h11; in_ctrl = 8'h01; out_ready = 1'b1;
    step();
    chk("s1_valid", out_valid, 1);
    chk("s1_data", out_data, 32'h11);
    chk("s1_ctrl", out_ctrl, 8'h01);
    chk("s1_level", level, 1);
    chk("s1_in_ready", in_ready, 1);
    in_data = 32'h22; in_ctrl = 8'h02;
    step();
    chk("s2_data", out_data, 32'h22);
    chk("s2_level", level, 1);
    chk("s2_in_ready", in_ready, 1);
    in_data = 32'h33; in_ctrl = 8'h03;
    step();
    chk("s3_data", out_data, 32'h33);
    chk("s3_level", level, 1);
    in_valid = 1'b0;
    step();
    chk("s_drain_valid", out_valid, 0);
    chk("s_drain_ctrl", out_ctrl, 0);
    chk("s_drain_level", level, 0);

    // Back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 32'hA0; in_ctrl = 8'h0A;
    step();
    chk("bp1_level", level, 1);
    in_data = 32'hA1; in_ctrl = 8'h0B;
    step();
    chk("bp2_level", level, 2);
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_data", out_data, 32'hA0);
    in_valid = 1'b0;
    step();
    chk("bp_hold_data", out_data, 32'hA0);
    chk("bp_hold_ctrl", out_ctrl, 8'h0A);
    chk("bp_hold_level", level, 2);
    out_ready = 1'b1;
    step();
    chk("bp_rel1_data", out_data, 32'hA1);
    chk("bp_rel1_ctrl", out_ctrl, 8'h0B);
    chk("bp_rel1_level", level, 1);
    step();
    chk("bp_rel2_level", level, 0);
    chk("bp_rel2_valid", out_valid, 0);

    // Flush while FULL with a pending producer
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hB0; in_ctrl = 8'h5A;
    step();
    in_data = 32'hB1;
    step();
    chk("fl_full_level", level, 2);
    flush = 1'b1; in_data = 32'hFF; in_ctrl = 8'hFF;
    step();
    chk("fl_level", level, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", out_ctrl, 0);
    chk("fl_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_ff_valid", out_valid, 0);

    // Flush in BUSY swallows a same-cycle input
    in_valid = 1'b1; in_data = 32'hC0; in_ctrl = 8'h0C; out_ready = 1'b0;
    step();
    chk("flb_level", level, 1);
    flush = 1'b1; in_data = 32'hFF; in_ctrl = 8'hFF;
    step();
    chk("flb_after_level", level, 0);
    chk("flb_after_valid", out_valid, 0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("flb_stays_empty", level, 0);

    // Control bundle zeroed on bubble; data holds
    in_valid = 1'b1; in_data = 32'hD0; in_ctrl = 8'hFF; out_ready = 1'b1;
    step();
    chk("bub_ctrl_live", out_ctrl, 8'hFF);
    in_valid = 1'b0;
    step();
    chk("bub_valid", out_valid, 0);
    chk("bub_ctrl_zero", out_ctrl, 8'h00);
    chk("bub_data_hold", out_data, 32'hD0);

    // Synchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hE0;
    step();
    in_data = 32'hE1;
    step();
    chk("rf_level", level, 2);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("rf_in_ready_rst", in_ready, 0);
    step();
    chk("rf_level0", level, 0);
    chk("rf_valid0", out_valid, 0);
    chk("rf_data0", out_data, 0);
    chk("rf_stall0", stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("rf_in_ready_after", in_ready, 1);

    // Stall counter: hold a valid head against a stalled consumer
    in_valid = 1'b1; in_data = 32'hF0; in_ctrl = 8'h0F; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("st_start", stall_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("st_cyc%0d", i), stall_cnt, stall_exp[i]);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush_keeps", stall_cnt, stall_exp[4]);
    chk("st_flush_level", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised successor to the fixed-field inter-stage registers (ID/EX style).
- Carries one opaque data bundle plus a control bundle between any two pipeline stages.
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not create a combinational ready path across stages.
- Adds synchronous flush and bubble semantics: control bits are forced to 0 whenever the output is invalid, so write enables cannot leak.

Parameters:
- DATA_W, 32: width of the data bundle (operands, pc4, imm, etc., concatenated).
- CTRL_W, 8: width of the control bundle (w_rf, w_dm, w_hi, w_lo, etc.); zeroed on bubble.
- CNT_W, 16: width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  producer has a bundle.
- in_ready  out  1  stage can accept a bundle; equals (state != FULL) && !rst, decoded from registered state only.
- in_data  in  DATA_W  producer data.
- in_ctrl  in  CTRL_W  producer control.
- out_valid  out  1  out_data/out_ctrl are valid.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_W  head data.
- out_ctrl  out  CTRL_W  head control; 0 when out_valid=0.
- level  out  2  occupancy: 0, 1 or 2.
- stall_cnt  out  CNT_W  stall-cycle count; constant 0 when the feature is absent.

Behaviour:
- Definitions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Storage: main entry (drives the outputs) and skid entry. Each entry holds data and ctrl.
- States: EMPTY (level 0), BUSY (level 1, main valid), FULL (level 2, main and skid valid).
- Reset (rst=1 at an edge): state EMPTY; out_valid 0; out_data 0; out_ctrl 0; level 0; stall_cnt 0; skid contents 0.
- Combinational: in_ready is 0 while rst is high.
- Priority: rst > flush > normal transitions.
- EMPTY:
  - in_fire: main <= in, go to BUSY.
  - Otherwise: stay.
- BUSY:
  - in_fire && out_fire: main <= in, stay BUSY.
  - in_fire && !out_fire: skid <= in, go to FULL.
  - !in_fire && out_fire: go to EMPTY.
  - Otherwise: hold.
- FULL:
  - in_ready=0, so no input is accepted.
  - out_fire: main <= skid, go to BUSY.
  - Otherwise: hold.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty.
- Throughput: 1 bundle per cycle while out_ready stays high.
- Ordering: strict FIFO, no duplication, no loss except on flush.
- Flush:
  - Next state is EMPTY; out_valid 0, out_ctrl 0, level 0.
  - An in_fire in the same cycle is consumed (producer sees a handshake) and discarded.
  - An out_fire in the same cycle completes normally; the consumer owns that bundle.
- Bubble:
  - When out_valid=0, out_ctrl reads 0.
  - out_data holds its last value; it is not required to be 0 except after reset.
- Stability: while out_valid=1 && out_ready=0, out_data/out_ctrl must not change.
- Producer rule: the producer may drop in_valid at any time. The stage never depends on in_valid being held.
- Reset mid-operation: held entries are lost; the first cycle after rst falls is EMPTY with in_ready=1.

Optional Feature:
- Macro: PIPE_SKID_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared by rst only; flush does not clear it.
- Undefined: counter logic is absent and stall_cnt is tied to 0.

Decomposition:
- Package pipe_skid_pkg:
  - State typedef pipe_skid_state_t (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10).
  - LEVEL_W=2 constant.
- Sub-module pipe_stall_counter (saturating up-counter; CNT_W parameter; clk/rst/inc inputs; count output). Instantiated only under PIPE_SKID_STALL_CNT_EN.
- Entry storage stays inline.

Test Plan:
- Reset then stream: rst for 2 cycles, then send 0x11, 0x22, 0x33 with out_ready=1 -> out_valid rises 1 cycle after the first in_fire; outputs 0x11, 0x22, 0x33 on consecutive cycles; level stays 1; in_ready stays 1.
- Back-pressure: out_ready=0, send 0xA0 then 0xA1 -> level 2, in_ready=0, out_data=0xA0 stable. Raise out_ready -> 0xA0 then 0xA1 delivered; level 2→1→0.
- Flush when FULL with in_valid=1: flush=1, in_data=0xFF -> next cycle level 0, out_valid 0, out_ctrl 0; 0xFF never appears on the output.
- Bubble control: in_ctrl=8'hFF accepted, then in_valid=0 -> after drain, out_ctrl=8'h00 while out_valid=0.
- Sync reset mid-FULL: rst=1 for 1 cycle -> state EMPTY and out_valid 0 after that edge; in_ready low during rst, high the next cycle.
- PIPE_SKID_STALL_CNT_EN with CNT_W=2: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt reads 1, 2, 3, 3, 3. Without the macro: stall_cnt is always 0.
